// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake bundle between EX/MEM and the MEM-stage LSU.
// Master drives requests and consumes responses; slave is the LSU.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [1:0]  resp_cause;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        input  resp_cause
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        output resp_cause
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: decodes faults, drives dmem for one
// access cycle and returns a registered response.
module lsu_mem_ctrl #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset,
    lsu_mem_ctrl_if.slave bus,
    output logic         dm_W_en,
    output logic         dm_R_en,
    output logic [31:0]  dm_addr,
    output logic [2:0]   dm_RW_type,
    output logic [31:0]  dm_din,
    input  logic [31:0]  dm_dout,
    output logic [31:0]  cnt_load,
    output logic [31:0]  cnt_store,
    output logic [31:0]  cnt_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_req_ready;
    logic        w_acc;
    logic        w_illegal;
    logic        w_mis;
    logic        w_oor;
    logic        w_err;
    logic [1:0]  w_cause;
    logic        w_good_ld;
    logic        w_good_st;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_err;
    logic [1:0]  r_cause;
    logic [31:0] r_resp_rdata;
    logic [4:0]  r_resp_rd;
    logic        r_resp_err;
    logic [1:0]  r_resp_cause;
    logic [31:0] r_cnt_load;
    logic [31:0] r_cnt_store;
    logic [31:0] r_cnt_err;

    // Fault decode on the live request; priority illegal > misaligned > range
    always_comb begin
        w_illegal = 1'b0;
        if (bus.req_we)
            w_illegal = (bus.req_funct3 != 3'b000) &&
                        (bus.req_funct3 != 3'b001) &&
                        (bus.req_funct3 != 3'b010);
        else
            w_illegal = (bus.req_funct3 == 3'b011) ||
                        (bus.req_funct3 == 3'b110) ||
                        (bus.req_funct3 == 3'b111);
        w_mis = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_funct3[1:0] == 2'b10) &&
                 (bus.req_addr[1:0] != 2'b00));
        w_oor = {2'b00, bus.req_addr[31:2]} >= 32'(DMEM_WORDS);
        w_err = w_illegal | w_mis | w_oor;
        w_cause = 2'b00;
        if (w_illegal)
            w_cause = 2'b11;
        else if (w_mis)
            w_cause = bus.req_we ? 2'b01 : 2'b00;
        else if (w_oor)
            w_cause = 2'b10;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_next = ACCESS;
            end
            ACCESS: w_next = RESP;
            RESP: begin
                w_req_ready = bus.resp_ready;
                if (bus.resp_ready)
                    w_next = bus.req_valid ? ACCESS : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    assign w_acc     = bus.req_valid & w_req_ready;
    assign w_good_ld = (r_state == ACCESS) & ~r_we & ~r_err;
    assign w_good_st = (r_state == ACCESS) & r_we & ~r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rd         <= 5'd0;
            r_err        <= 1'b0;
            r_cause      <= 2'b00;
            r_resp_rdata <= 32'h0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= 2'b00;
            r_cnt_load   <= 32'h0;
            r_cnt_store  <= 32'h0;
            r_cnt_err    <= 32'h0;
        end else begin
            if (w_acc) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_rd     <= bus.req_rd;
                r_err    <= w_err;
                r_cause  <= w_cause;
            end
            if (r_state == ACCESS) begin
                r_resp_rdata <= w_good_ld ? dm_dout : 32'h0;
                r_resp_rd    <= r_rd;
                r_resp_err   <= r_err;
                r_resp_cause <= r_err ? r_cause : 2'b00;
                if (w_good_ld) r_cnt_load  <= r_cnt_load + 32'd1;
                if (w_good_st) r_cnt_store <= r_cnt_store + 32'd1;
                if (r_err)     r_cnt_err   <= r_cnt_err + 32'd1;
            end
        end
    end

    // Write enable gated by reset so a reset mid-access never commits
    assign dm_W_en    = w_good_st & ~reset;
    assign dm_R_en    = w_good_ld;
    assign dm_addr    = r_addr;
    assign dm_RW_type = r_funct3;
    assign dm_din     = r_wdata;

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_cause = r_resp_cause;

    assign cnt_load  = r_cnt_load;
    assign cnt_store = r_cnt_store;
    assign cnt_err   = r_cnt_err;
endmodule
